fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side companion to the FIFO: drains words from the FIFO output port with the valid/yumi handshake and checks each popped word against an expected incrementing sequence. Applies programmable backpressure, counts words and mismatches, and captures the first mismatch. Sits at the FIFO output in the mp1 FIFO testbench and in self-checking loopback builds.

## Interface
- WIDTH, 8, data word width (matches `word_t`)
- STRIDE, 1, increment applied to the expected value after each pop
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a read run (ignored unless IDLE)
- count_i  in  16  words to consume; latched on accepted start
- throttle_i  in  4  idle cycles inserted after each pop; latched on start
- seed_i  in  WIDTH  first expected word; latched on start
- valid_i  in  1  FIFO output valid (FIFO `valid_o`)
- data_i  in  WIDTH  FIFO output data (FIFO `data_o`)
- yumi  out  1  pop acknowledge to FIFO
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- mismatch  out  1  one-cycle pulse, registered, cycle after a bad pop
- rd_cnt  out  16  words popped this run
- err_cnt  out  16  mismatching words this run, saturates at 0xFFFF
- first_err_idx  out  16  index (0-based) of first mismatch
- first_err_data  out  WIDTH  data of first mismatch

## Operation
- Reset: all outputs 0, state IDLE, latched registers 0. `yumi` is forced 0 in any cycle where `reset`=1, including reset asserted mid-run.
- States: IDLE, POP, WAIT, DONE.
- IDLE: on `start`, latch count/throttle/seed into expected register; clear rd_cnt, err_cnt, first_err_*; go POP if count_i≠0, else DONE.
- POP: `yumi` = `valid_i` (combinational, only in POP). A pop occurs on a clock edge with yumi=1. On pop: compare `data_i` to expected; rd_cnt+1; expected += STRIDE modulo 2^WIDTH (wraps); on mismatch err_cnt+1 (saturating), mismatch=1 next cycle, and if err_cnt was 0, record first_err_idx=rd_cnt (pre-increment), first_err_data=data_i. Next state: DONE if this was word count_i; else WAIT if throttle≠0 (load down-counter with throttle); else stay POP. With `valid_i`=0, stay POP, no side effects.
- WAIT: yumi=0; decrement counter; go POP when counter reaches 1 after decrement to 0 (exactly throttle cycles in WAIT).
- DONE: done=1 for exactly one cycle, then IDLE. Counters and first_err_* hold until the next accepted start.
- busy=1 in POP and WAIT only. `start` outside IDLE is ignored; latched values are unchanged.
- `data_i` is don't-care when `valid_i`=0 or state≠POP.

## Timing
- Start accepted at edge k → busy=1 and yumi may assert in cycle k+1.
- throttle=0: one pop per cycle while valid_i=1.
- throttle=T: successive pops spaced ≥T+1 cycles.
- Last pop at edge e → done=1 in cycle e+1, busy=0 in cycle e+1, IDLE at e+2; new start accepted in IDLE (cycle e+2 onward).
- count_i=0: start at edge k → done=1 in cycle k+1, no yumi.
- Outputs other than yumi are registered.

## Test plan
- Reset hold: reset=1 for 3 cycles with valid_i=1, start=1 → yumi=0 every cycle, busy=done=0, rd_cnt=err_cnt=0; reset asserted mid-run in POP with valid_i=1 → yumi=0 that cycle, IDLE after.
- Back-to-back: seed 0x10, count 4, throttle 0, valid_i=1, data 0x10..0x13 → yumi high 4 consecutive cycles, done one cycle later, rd_cnt=4, err_cnt=0, mismatch never asserted.
- Throttle: seed 0, count 3, throttle 2, valid_i=1 → yumi high in cycles 1, 4, 7 after start; done in cycle 8.
- Mismatch: seed 0x10, data 0x10, 0x99, 0x12, 0x77 → err_cnt=2, first_err_idx=1, first_err_data=0x99, mismatch pulses after pops 1 and 3.
- Stall and wrap: seed 0xFE, count 4, valid_i toggling 1,0,0,1,1,0,1 with correct data 0xFE,0xFF,0x00,0x01 → yumi only when valid_i=1, err_cnt=0, rd_cnt=4.
- Corner starts: count_i=0 → done next cycle, rd_cnt=0; start pulsed while busy with different seed → ignored, original run completes with original checks.

Source files
------------

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO output-side handshake (valid/yumi) between a FIFO
// and its reader.
//   valid_i : FIFO output word is valid       (FIFO -> reader)
//   data_i  : FIFO output word                 (FIFO -> reader)
//   yumi    : reader pops the current word    (reader -> FIFO)
// master = FIFO side, slave = reader side.
interface fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             yumi;

    modport master (
        output valid_i,
        output data_i,
        input  yumi
    );

    modport slave (
        input  valid_i,
        input  data_i,
        output yumi
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a FIFO through the valid/yumi handshake, checks every
// popped word against an incrementing expected sequence, inserts optional
// idle cycles after each pop, and reports word/mismatch counts plus the
// first mismatch seen in the run.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle pulse, starts a run when idle
//   count_i         : words to consume (latched on start)
//   throttle_i      : idle cycles after each pop (latched on start)
//   seed_i          : first expected word (latched on start)
//   fifo            : valid_i/data_i in, yumi out (slave modport)
//   busy            : run in progress (POP or WAIT)
//   done            : one-cycle pulse at end of run
//   mismatch        : one-cycle pulse the cycle after a bad pop
//   rd_cnt, err_cnt : words popped / mismatching words this run
//   first_err_idx   : 0-based index of the first mismatching word
//   first_err_data  : data of the first mismatching word
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start
// POP    | yumi follows valid_i; each pop is checked
// WAIT   | throttle gap after a pop, yumi held low
// DONE   | one-cycle done pulse, then back to IDLE
module fifo_reader #(
    parameter int WIDTH  = 8,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      count_i,
    input  logic [3:0]       throttle_i,
    input  logic [WIDTH-1:0] seed_i,
    fifo_reader_if.slave     fifo,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [15:0]      rd_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH-1:0] first_err_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [15:0]      count_r;
    logic [3:0]       throttle_r;
    logic [3:0]       wait_cnt;
    logic [WIDTH-1:0] expected;

    logic             pop;
    logic             bad;
    logic             last;
    logic [15:0]      rd_cnt_inc;

    // yumi must never reach the FIFO during reset, even mid-run
    assign fifo.yumi  = (state == S_POP) && fifo.valid_i && !reset;
    assign pop        = fifo.yumi;
    assign bad        = (fifo.data_i != expected);
    assign rd_cnt_inc = rd_cnt + 16'd1;
    assign last       = (rd_cnt_inc == count_r);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (count_i != 16'd0) ? S_POP : S_DONE;
                end
            end
            S_POP: begin
                if (pop) begin
                    if (last) begin
                        state_next = S_DONE;
                    end else if (throttle_r != 4'd0) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_POP;
                    end
                end
            end
            S_WAIT: begin
                // counter loaded with throttle: leaving on 1 gives exactly
                // throttle cycles in WAIT
                if (wait_cnt == 4'd1) begin
                    state_next = S_POP;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            count_r        <= '0;
            throttle_r     <= '0;
            wait_cnt       <= '0;
            expected       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch       <= 1'b0;
            rd_cnt         <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state_next == S_POP) || (state_next == S_WAIT);
            done     <= (state_next == S_DONE);
            mismatch <= pop && bad;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        count_r        <= count_i;
                        throttle_r     <= throttle_i;
                        expected       <= seed_i;
                        rd_cnt         <= '0;
                        err_cnt        <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                    end
                end
                S_POP: begin
                    if (pop) begin
                        rd_cnt   <= rd_cnt_inc;
                        expected <= expected + STEP;
                        if (bad) begin
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                            if (err_cnt == 16'd0) begin
                                first_err_idx  <= rd_cnt;
                                first_err_data <= fifo.data_i;
                            end
                        end
                        if (!last && (throttle_r != 4'd0)) begin
                            wait_cnt <= throttle_r;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [15:0]      count_i;
    logic [3:0]       throttle_i;
    logic [WIDTH-1:0] seed_i;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [15:0]      rd_cnt;
    logic [15:0]      err_cnt;
    logic [15:0]      first_err_idx;
    logic [WIDTH-1:0] first_err_data;

    int checks = 0;
    int errors = 0;

    fifo_reader_if #(.WIDTH(WIDTH)) fifo ();

    fifo_reader #(.WIDTH(WIDTH), .STRIDE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .count_i        (count_i),
        .throttle_i     (throttle_i),
        .seed_i         (seed_i),
        .fifo           (fifo.slave),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch),
        .rd_cnt         (rd_cnt),
        .err_cnt        (err_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs change here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] seed, input logic [15:0] cnt, input logic [3:0] thr);
        seed_i     = seed;
        count_i    = cnt;
        throttle_i = thr;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    int valid_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [7:0] wrap_seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] mm_seq   [4] = '{8'h10, 8'h99, 8'h12, 8'h77};

    initial begin
        int pidx;

        // reset hold with start and valid asserted
        reset        = 1'b1;
        start        = 1'b1;
        count_i      = 16'd5;
        throttle_i   = 4'd0;
        seed_i       = 8'h00;
        fifo.valid_i = 1'b1;
        fifo.data_i  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("rst_yumi", {31'd0, fifo.yumi}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
            chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        end
        start        = 1'b0;
        reset        = 1'b0;
        fifo.valid_i = 1'b0;
        cyc();

        // back-to-back, seed 0x10, count 4, throttle 0
        fifo.valid_i = 1'b1;
        fifo.data_i  = 8'h10;
        kick(8'h10, 16'd4, 4'd0);
        for (int i = 0; i < 4; i++) begin
            fifo.data_i = 8'(8'h10 + i);
            #1;
            chk("b2b_yumi", {31'd0, fifo.yumi}, 32'd1);
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            chk("b2b_mismatch", {31'd0, mismatch}, 32'd0);
            cyc();
        end
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);
        chk("b2b_yumi_end", {31'd0, fifo.yumi}, 32'd0);
        chk("b2b_rd_cnt", {16'd0, rd_cnt}, 32'd4);
        chk("b2b_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("b2b_mismatch_end", {31'd0, mismatch}, 32'd0);
        cyc();
        chk("b2b_done_pulse", {31'd0, done}, 32'd0);

        // throttle 2: pops in cycles 1, 4, 7; done in cycle 8
        fifo.data_i = 8'h00;
        kick(8'h00, 16'd3, 4'd2);
        for (int c = 1; c <= 8; c++) begin
            fifo.data_i = 8'((c - 1) / 3);
            #1;
            chk("thr_yumi", {31'd0, fifo.yumi}, {31'd0, (c % 3 == 1) && (c < 8)});
            chk("thr_done", {31'd0, done}, {31'd0, c == 8});
            cyc();
        end
        chk("thr_rd_cnt", {16'd0, rd_cnt}, 32'd3);
        chk("thr_err_cnt", {16'd0, err_cnt}, 32'd0);

        // mismatches at index 1 and 3
        fifo.data_i = 8'h10;
        kick(8'h10, 16'd4, 4'd0);
        for (int i = 0; i < 4; i++) begin
            fifo.data_i = mm_seq[i];
            #1;
            chk("mm_yumi", {31'd0, fifo.yumi}, 32'd1);
            chk("mm_pulse", {31'd0, mismatch}, {31'd0, i == 2});
            cyc();
        end
        chk("mm_pulse_last", {31'd0, mismatch}, 32'd1);
        chk("mm_done", {31'd0, done}, 32'd1);
        chk("mm_err_cnt", {16'd0, err_cnt}, 32'd2);
        chk("mm_first_idx", {16'd0, first_err_idx}, 32'd1);
        chk("mm_first_data", {24'd0, first_err_data}, 32'h99);
        chk("mm_rd_cnt", {16'd0, rd_cnt}, 32'd4);
        cyc();
        chk("mm_pulse_clear", {31'd0, mismatch}, 32'd0);
        chk("mm_hold_idx", {16'd0, first_err_idx}, 32'd1);

        // stall and wrap from 0xFE
        fifo.valid_i = 1'b0;
        kick(8'hFE, 16'd4, 4'd0);
        pidx = 0;
        for (int i = 0; i < 7; i++) begin
            fifo.valid_i = valid_pat[i][0];
            fifo.data_i  = (valid_pat[i] != 0) ? wrap_seq[pidx] : 8'hAA;
            #1;
            chk("wrap_yumi", {31'd0, fifo.yumi}, {31'd0, valid_pat[i] != 0});
            if (valid_pat[i] != 0) pidx++;
            cyc();
        end
        chk("wrap_done", {31'd0, done}, 32'd1);
        chk("wrap_rd_cnt", {16'd0, rd_cnt}, 32'd4);
        chk("wrap_err_cnt", {16'd0, err_cnt}, 32'd0);
        fifo.valid_i = 1'b1;
        cyc();

        // count 0: done next cycle, no yumi
        kick(8'h00, 16'd0, 4'd0);
        #1;
        chk("cnt0_done", {31'd0, done}, 32'd1);
        chk("cnt0_busy", {31'd0, busy}, 32'd0);
        chk("cnt0_yumi", {31'd0, fifo.yumi}, 32'd0);
        chk("cnt0_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        cyc();

        // start while busy is ignored; throttle 1 run of 3 from 0x40
        fifo.data_i = 8'h40;
        kick(8'h40, 16'd3, 4'd1);
        seed_i     = 8'h80;
        count_i    = 16'd9;
        throttle_i = 4'd0;
        for (int c = 1; c <= 6; c++) begin
            fifo.data_i = 8'(8'h40 + (c - 1) / 2);
            start       = (c == 2);
            #1;
            chk("ign_yumi", {31'd0, fifo.yumi}, {31'd0, (c % 2 == 1) && (c < 6)});
            chk("ign_done", {31'd0, done}, {31'd0, c == 6});
            cyc();
        end
        start = 1'b0;
        chk("ign_rd_cnt", {16'd0, rd_cnt}, 32'd3);
        chk("ign_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("ign_busy", {31'd0, busy}, 32'd0);

        // reset asserted mid-run while in POP with valid high
        fifo.data_i = 8'h00;
        kick(8'h00, 16'd5, 4'd0);
        #1;
        chk("midrst_pre_yumi", {31'd0, fifo.yumi}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_yumi", {31'd0, fifo.yumi}, 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        chk("midrst_idle_yumi", {31'd0, fifo.yumi}, 32'd0);
        cyc();
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
        chk("midrst_idle_yumi2", {31'd0, fifo.yumi}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
